// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg retiming pipeline.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register slot of the pipe_reg pipeline; clr_i wipes the
// valid bit regardless of advance, leaving stale data behind.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic             prev_valid_i,
    input  logic [WIDTH-1:0] prev_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: clear beats advance, advance loads the upstream slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = prev_valid_i;
            data_d  = prev_data_i;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg.sv
// WIDTH x DEPTH valid/ready register pipeline with bubble collapsing and flush.
// Optional PIPE_OCC_EN adds a registered occupancy count port.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready
`ifdef PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]   occupancy
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic             in_xfer_s;

    // Ready ripples from the output back to stage 0: a stage may move when
    // it is empty or the stage ahead of it is moving.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             adv_s;
        logic             prev_valid_s;
        logic [WIDTH-1:0] prev_data_s;

        if (i == DEPTH - 1) begin : g_last
            assign adv_s = out_ready | ~valid_s[i];
        end else begin : g_mid
            assign adv_s = g_stage[i+1].adv_s | ~valid_s[i];
        end

        if (i == 0) begin : g_first
            assign prev_valid_s = in_xfer_s;
            assign prev_data_s  = in_data;
        end else begin : g_chain
            assign prev_valid_s = valid_s[i-1];
            assign prev_data_s  = data_s[i-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock        (clock),
            .reset_n      (reset_n),
            .clr_i        (flush),
            .adv_i        (adv_s),
            .prev_valid_i (prev_valid_s),
            .prev_data_i  (prev_data_s),
            .valid_o      (valid_s[i]),
            .data_o       (data_s[i])
        );
    end

    assign in_ready  = reset_n & ~flush & g_stage[0].adv_s;
    assign in_xfer_s = in_valid & in_ready;
    assign out_valid = valid_s[DEPTH-1];
    assign out_data  = data_s[DEPTH-1];

`ifdef PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic             out_xfer_s;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    assign out_xfer_s = valid_s[DEPTH-1] & out_ready;

    // Track the valid-bit population incrementally alongside the stages.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer_s && !out_xfer_s) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer_s && out_xfer_s) begin
            occ_d = occ_q - OCC_W'(1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: a DEPTH=3 and a DEPTH=1 instance, each checked against a
// queue-based reference model (words plus acceptance cycle) by a negedge monitor.
module tb_pipe_reg;

    localparam int W = 8;
    localparam int DEP [2] = '{3, 1};

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    iv;
    logic [1:0]    ord;
    logic [1:0]    fl;
    logic [1:0]    irdy;
    logic [1:0]    ov;
    logic [W-1:0]  idat [2];
    logic [W-1:0]  od   [2];
`ifdef PIPE_OCC_EN
    logic [1:0]    occ0;
    logic [0:0]    occ1;
`endif

    ent_t          sbq [2][$];
    logic [1:0]    exp_rdy;
    int            cyc;
    int            n_vec;
    int            n_err;

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .clock     (clk),
        .reset_n   (reset_n),
        .flush     (fl[0]),
        .in_valid  (iv[0]),
        .in_data   (idat[0]),
        .in_ready  (irdy[0]),
        .out_valid (ov[0]),
        .out_data  (od[0]),
        .out_ready (ord[0])
`ifdef PIPE_OCC_EN
        ,
        .occupancy (occ0)
`endif
    );

    pipe_reg #(.WIDTH(W), .DEPTH(1)) u_dut1 (
        .clock     (clk),
        .reset_n   (reset_n),
        .flush     (fl[1]),
        .in_valid  (iv[1]),
        .in_data   (idat[1]),
        .in_ready  (irdy[1]),
        .out_valid (ov[1]),
        .out_data  (od[1]),
        .out_ready (ord[1])
`ifdef PIPE_OCC_EN
        ,
        .occupancy (occ1)
`endif
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic chk_occ(input int d, input int exp);
`ifdef PIPE_OCC_EN
        chk("occupancy", d, (d == 0) ? 32'(occ0) : 32'(occ1), 32'(exp));
`else
        if (d < 0) $display("dut%0d occupancy %0d", d, exp);
`endif
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
            chk("rst_out_data", d, 32'(od[d]), 32'd0);
            chk("rst_in_ready", d, 32'(irdy[d]), 32'd0);
            chk_occ(d, 0);
        end
    endtask

    // Monitor: compare what each DUT presents with the model's head word.
    task automatic monitor(input int d);
        logic ev;
        if (reset_n !== 1'b1) return;
        ev = (sbq[d].size() > 0) && ((cyc - sbq[d][0].t) >= DEP[d] - 1);
        chk("out_valid", d, 32'(ov[d]), 32'(ev));
        chk("in_ready", d, 32'(irdy[d]), 32'(exp_rdy[d]));
        chk_occ(d, sbq[d].size());
        if (ev) begin
            chk("out_data", d, 32'(od[d]), 32'(sbq[d][0].d));
            if (ord[d]) void'(sbq[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    task automatic drv(input int d, input logic v, input logic [W-1:0] x, input logic r, input logic f);
        iv[d]   = v;
        idat[d] = x;
        ord[d]  = r;
        fl[d]   = f;
    endtask

    // Predict readiness, clock once, then record accepted words or a flush.
    task automatic cycle();
        for (int d = 0; d < 2; d++)
            exp_rdy[d] = reset_n && !fl[d] && ((sbq[d].size() < DEP[d]) || ord[d]);
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (fl[d]) sbq[d].delete();
            else if (iv[d] && exp_rdy[d]) sbq[d].push_back('{idat[d], cyc});
        end
        #2;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; exp_rdy = 2'b00;
        iv = 2'b00; ord = 2'b11; fl = 2'b00;
        idat[0] = 8'h00; idat[1] = 8'h00;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk_reset();
        reset_n = 1'b1;

        // Streaming back to back with out_ready high.
        drv(0, 1'b1, 8'h11, 1'b1, 1'b0); cycle();
        drv(0, 1'b1, 8'h22, 1'b1, 1'b0); cycle();
        drv(0, 1'b1, 8'h33, 1'b1, 1'b0); cycle();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); repeat (4) cycle();

        // Backpressure: five offered, three absorbed, then release.
        for (int k = 0; k < 5; k++) begin
            drv(0, 1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0); cycle();
        end
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); repeat (4) cycle();

        // Bubble collapse of a single word into the output stage.
        drv(0, 1'b1, 8'h5A, 1'b0, 1'b0); cycle();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0); repeat (5) cycle();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); repeat (2) cycle();

        // Flush with a word offered in the flush cycle.
        drv(0, 1'b1, 8'h01, 1'b0, 1'b0); cycle();
        drv(0, 1'b1, 8'h02, 1'b0, 1'b0); cycle();
        drv(0, 1'b1, 8'h03, 1'b0, 1'b1); cycle();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); repeat (4) cycle();

        // Asynchronous reset with words in flight.
        drv(0, 1'b1, 8'hC1, 1'b0, 1'b0); drv(1, 1'b1, 8'hD1, 1'b0, 1'b0); cycle();
        drv(0, 1'b1, 8'hC2, 1'b0, 1'b0); cycle();
        reset_n = 1'b0;
        #1;
        chk_reset();
        sbq[0].delete(); sbq[1].delete();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); drv(1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle();
        chk_reset();
        reset_n = 1'b1;
        drv(0, 1'b1, 8'h77, 1'b1, 1'b0); cycle();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); repeat (3) cycle();

        // DEPTH=1: continuous input, alternating out_ready.
        for (int k = 0; k < 20; k++) begin
            drv(1, 1'b1, 8'($urandom), (k % 2) == 0, 1'b0); cycle();
        end

        // Randomized traffic on both instances.
        for (int k = 0; k < 600; k++) begin
            for (int d = 0; d < 2; d++)
                drv(d, $urandom_range(3) != 0, 8'($urandom), $urandom_range(2) != 0,
                    $urandom_range(40) == 0);
            cycle();
        end

        // Drain and confirm nothing was lost.
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0); drv(1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) cycle();
        for (int d = 0; d < 2; d++) chk("drained", d, 32'(sbq[d].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
